// File: rtl/sm_disp_pkg.sv
// Shared definitions for the sign-magnitude 7-segment display controller:
// FSM state encodings, segment constants, digit-to-segment table and the
// shift-add-3 nibble correction used by the binary-to-BCD sequencer.
package sm_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Segment patterns are active-low gfedcba.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  localparam int BCD_W = 12;

  // 0-9 segment table; anything else is blanked.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble correction: a nibble of 5 or more would overflow past 9
  // after the next shift, so pre-add 3.
  function automatic logic [3:0] add3_if_ge5(input logic [3:0] n);
    logic [3:0] r;
    if (n >= 4'd5) begin
      r = n + 4'd3;
    end else begin
      r = n;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (one magnitude bit per clock).
// Captures sign/magnitude into shadow registers on load, so the inputs may
// change freely afterwards. done pulses for the single COMMIT cycle, during
// which bcd/sign_q are stable and ready to be committed by the parent.
module bin2bcd_seq
  import sm_disp_pkg::*;
#(
  parameter int W_MAG = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             sign,
  input  logic [W_MAG-1:0] mag,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd,
  output logic             sign_q
);

  localparam int CW = $clog2(W_MAG + 1);

  state_t                  state_r;
  state_t                  next_state_s;
  logic [CW-1:0]           cnt_r;
  logic [W_MAG-1:0]        bin_r;
  logic [BCD_W-1:0]        bcd_r;
  logic                    sign_r;
  logic                    busy_r;
  logic                    done_r;
  logic [BCD_W-1:0]        bcd_adj_s;
  logic [BCD_W+W_MAG-1:0]  shift_s;

  // Next-state logic: IDLE -> CONV on load, CONV for W_MAG cycles, COMMIT once.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (load) begin
          next_state_s = ST_CONV;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CONV: begin
        if (cnt_r == CW'(W_MAG - 1)) begin
          next_state_s = ST_COMMIT;
        end else begin
          next_state_s = ST_CONV;
        end
      end
      ST_COMMIT: next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Shift-add-3 step: correct each BCD nibble, then shift {bcd, bin} left by one.
  always_comb begin
    bcd_adj_s = {add3_if_ge5(bcd_r[11:8]), add3_if_ge5(bcd_r[7:4]), add3_if_ge5(bcd_r[3:0])};
    shift_s   = {bcd_adj_s, bin_r} << 1'b1;
  end

  // State register with busy/done registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != ST_IDLE);
      done_r  <= (next_state_s == ST_COMMIT);
    end
  end

  // Shadow capture and conversion datapath; a reset discards any partial result.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= {CW{1'b0}};
      bin_r  <= {W_MAG{1'b0}};
      bcd_r  <= {BCD_W{1'b0}};
      sign_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (load) begin
            bin_r  <= mag;
            sign_r <= sign;
            bcd_r  <= {BCD_W{1'b0}};
            cnt_r  <= {CW{1'b0}};
          end
        end
        ST_CONV: begin
          bcd_r <= shift_s[BCD_W+W_MAG-1:W_MAG];
          bin_r <= shift_s[W_MAG-1:0];
          cnt_r <= cnt_r + CW'(1);
        end
        default: begin
          bcd_r <= bcd_r;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign bcd    = bcd_r;
  assign sign_q = sign_r;

endmodule

// File: rtl/sign_mag_display_ctrl.sv
// 7-segment display sequencer for the sign-magnitude adder result.
// Converts {sign, mag} to three BCD digits via bin2bcd_seq and scans a
// 4-digit common-anode display: an[3]=sign, an[2]=hundreds, an[1]=tens,
// an[0]=units. Segment and anode outputs are active-low and registered
// together so they never disagree.
// Optional feature macro: LZ_BLANK_EN -- blanks leading zeros in the
// hundreds and tens digits (units always shown).
module sign_mag_display_ctrl
  import sm_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int W_MAG       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             sign,
  input  logic [W_MAG-1:0] mag,
  output logic             busy,
  output logic             done,
  output logic [3:0]       an,
  output logic [7:0]       sseg
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [BCD_W-1:0] conv_bcd;
  logic             conv_sign;
  logic             conv_done;
  logic [PW-1:0]    presc_r;
  logic [1:0]       idx_r;
  logic [3:0]       hund_r;
  logic [3:0]       tens_r;
  logic [3:0]       units_r;
  logic             sign_r;
  logic [3:0]       an_r;
  logic [7:0]       sseg_r;
  logic             nonzero_s;
  logic             blank_hund_s;
  logic             blank_tens_s;
  logic [6:0]       seg_s;

  bin2bcd_seq #(
    .W_MAG (W_MAG)
  ) u_conv (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .sign   (sign),
    .mag    (mag),
    .busy   (busy),
    .done   (conv_done),
    .bcd    (conv_bcd),
    .sign_q (conv_sign)
  );

  assign done = conv_done;

  // Commit the converted digits and sign at the end of the COMMIT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hund_r  <= 4'd0;
      tens_r  <= 4'd0;
      units_r <= 4'd0;
      sign_r  <= 1'b0;
    end else if (conv_done) begin
      hund_r  <= conv_bcd[11:8];
      tens_r  <= conv_bcd[7:4];
      units_r <= conv_bcd[3:0];
      sign_r  <= conv_sign;
    end
  end

  // Free-running refresh prescaler; each wrap advances the scanned digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r <= {PW{1'b0}};
      idx_r   <= 2'd0;
    end else if (presc_r == PW'(REFRESH_DIV - 1)) begin
      presc_r <= {PW{1'b0}};
      idx_r   <= idx_r + 2'd1;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Digit select, leading-zero policy and segment decode for the scanned slot.
  always_comb begin
    nonzero_s = (hund_r != 4'd0) || (tens_r != 4'd0) || (units_r != 4'd0);
`ifdef LZ_BLANK_EN
    blank_hund_s = (hund_r == 4'd0);
    blank_tens_s = (hund_r == 4'd0) && (tens_r == 4'd0);
`else
    blank_hund_s = 1'b0;
    blank_tens_s = 1'b0;
`endif
    seg_s = SEG_BLANK;
    case (idx_r)
      2'd0: seg_s = seg_digit(units_r);
      2'd1: begin
        if (blank_tens_s) begin
          seg_s = SEG_BLANK;
        end else begin
          seg_s = seg_digit(tens_r);
        end
      end
      2'd2: begin
        if (blank_hund_s) begin
          seg_s = SEG_BLANK;
        end else begin
          seg_s = seg_digit(hund_r);
        end
      end
      2'd3: begin
        // Negative zero is shown as a plain (unsigned) zero.
        if (sign_r && nonzero_s) begin
          seg_s = SEG_MINUS;
        end else begin
          seg_s = SEG_BLANK;
        end
      end
      default: seg_s = SEG_BLANK;
    endcase
  end

  // Register anode and segment outputs from the same scan index on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_r   <= 4'b1110;
      sseg_r <= 8'hFF;
    end else begin
      an_r   <= ~(4'b0001 << idx_r);
      sseg_r <= {1'b1, seg_s};
    end
  end

  assign an   = an_r;
  assign sseg = sseg_r;

endmodule

// File: tb/tb_sign_mag_display_ctrl.sv
// Self-checking bench for sign_mag_display_ctrl (REFRESH_DIV=4, W_MAG=8).
// Table of {sign, mag, expected sign/hund/tens/units segments} plus
// hand-written sequences for dropped load, mid-conversion reset and
// back-to-back loads. Expectations go into a scoreboard queue at load time
// and are popped when done is observed.
module tb_sign_mag_display_ctrl;

  localparam int W_MAG       = 8;
  localparam int REFRESH_DIV = 4;
  localparam int LAT         = W_MAG + 1;
`ifdef LZ_BLANK_EN
  localparam logic [7:0] HZ = 8'hFF;
`else
  localparam logic [7:0] HZ = 8'hC0;
`endif

  typedef struct {
    logic       s;
    logic [7:0] m;
    logic [7:0] e3;
    logic [7:0] e2;
    logic [7:0] e1;
    logic [7:0] e0;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic       sign;
  logic [7:0] mag;
  logic       busy;
  logic       done;
  logic [3:0] an;
  logic [7:0] sseg;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  vec_t sb[$];
  vec_t tbl[10];
  vec_t bb[4];

  sign_mag_display_ctrl #(
    .REFRESH_DIV (REFRESH_DIV),
    .W_MAG       (W_MAG)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .sign  (sign),
    .mag   (mag),
    .busy  (busy),
    .done  (done),
    .an    (an),
    .sseg  (sseg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input vec_t v);
    load = 1'b1;
    sign = v.s;
    mag  = v.m;
  endtask

  // Waits for done (bounded). Inputs are scrambled right after the load edge.
  // A non-zero pulse_at drives a stray load with mag=200 at that CONV sample.
  task automatic wait_done(input int pulse_at, output int k, output int bh);
    k  = 0;
    bh = 0;
    while (k < 40) begin
      tick();
      k++;
      if (k == 1) begin
        load = 1'b0;
        sign = 1'($urandom_range(0, 1));
        mag  = 8'($urandom_range(0, 255));
      end
      if (pulse_at != 0 && k == pulse_at) begin
        load = 1'b1;
        sign = 1'b1;
        mag  = 8'd200;
      end
      if (pulse_at != 0 && k == pulse_at + 1) load = 1'b0;
      if (busy === 1'b1) bh++;
      if (done === 1'b1) break;
    end
  endtask

  // After a done sample: skip the commit edge, then scan 16 cycles and compare every slot.
  task automatic check_disp(input vec_t v, input string tag);
    logic [7:0] cap[4];
    for (int i = 0; i < 4; i++) cap[i] = 8'h00;
    tick();
    chk({tag, "_done_width"}, done, 1'b0);
    for (int i = 0; i < 16; i++) begin
      tick();
      case (an)
        4'b1110: cap[0] = sseg;
        4'b1101: cap[1] = sseg;
        4'b1011: cap[2] = sseg;
        4'b0111: cap[3] = sseg;
        default: chk({tag, "_an_onehot"}, an, 4'b1110);
      endcase
    end
    chk({tag, "_sign"}, cap[3], v.e3);
    chk({tag, "_hund"}, cap[2], v.e2);
    chk({tag, "_tens"}, cap[1], v.e1);
    chk({tag, "_units"}, cap[0], v.e0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   k;
    int   bh;
    vec_t e;
    sb.push_back(v);
    start_load(v);
    wait_done(0, k, bh);
    chk({tag, "_latency"}, k, LAT);
    chk({tag, "_busy_cycles"}, bh, LAT);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_disp(e, tag);
    end else begin
      chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    int         k;
    int         bh;
    int         dc0;
    int         dprev;
    logic [3:0] one;
    logic [3:0] exp_an;
    vec_t       v;
    vec_t       e;

    tbl[0] = '{1'b0, 8'd255, 8'hFF, 8'hA4, 8'h92, 8'h92};
    tbl[1] = '{1'b1, 8'd128, 8'hBF, 8'hF9, 8'hA4, 8'h80};
    tbl[2] = '{1'b1, 8'd0,   8'hFF, HZ,    HZ,    8'hC0};
    tbl[3] = '{1'b0, 8'd7,   8'hFF, HZ,    HZ,    8'hF8};
    tbl[4] = '{1'b1, 8'd9,   8'hBF, HZ,    HZ,    8'h90};
    tbl[5] = '{1'b0, 8'd100, 8'hFF, 8'hF9, 8'hC0, 8'hC0};
    tbl[6] = '{1'b1, 8'd99,  8'hBF, HZ,    8'h90, 8'h90};
    tbl[7] = '{1'b0, 8'd10,  8'hFF, HZ,    8'hF9, 8'hC0};
    tbl[8] = '{1'b1, 8'd250, 8'hBF, 8'hA4, 8'h92, 8'hC0};
    tbl[9] = '{1'b0, 8'd64,  8'hFF, HZ,    8'h82, 8'h99};

    bb[0] = '{1'b0, 8'd45,  8'hFF, HZ,    8'h99, 8'h92};
    bb[1] = '{1'b1, 8'd201, 8'hBF, 8'hA4, 8'hC0, 8'hF9};
    bb[2] = '{1'b0, 8'd38,  8'hFF, HZ,    8'hB0, 8'h80};
    bb[3] = '{1'b1, 8'd163, 8'hBF, 8'hF9, 8'h82, 8'hB0};

    reset = 1'b1;
    load  = 1'b0;
    sign  = 1'b0;
    mag   = 8'd0;
    repeat (3) tick();
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_an", an, 4'b1110);
    chk("reset_sseg", sseg, 8'hFF);
    reset = 1'b0;

    // Scan: each anode held for REFRESH_DIV clocks, rotating from units.
    one = 4'b0001;
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp_an = ~(one << ((i - 1) / REFRESH_DIV));
      chk("an_scan", an, exp_an);
    end

    // Table-driven conversions.
    for (int i = 0; i < 10; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Load during CONV is dropped; single done; original value displayed.
    v = '{1'b0, 8'd7, 8'hFF, HZ, HZ, 8'hF8};
    sb.push_back(v);
    dc0 = done_cnt;
    start_load(v);
    wait_done(3, k, bh);
    chk("drop_latency", k, LAT);
    e = sb.pop_front();
    check_disp(e, "drop");
    chk("drop_single_done", done_cnt - dc0, 1);
    chk("drop_idle", busy, 1'b0);

    // Reset for one cycle at CONV cycle 4.
    v = '{1'b1, 8'd123, 8'hBF, 8'hF9, 8'hA4, 8'hB0};
    start_load(v);
    tick();
    load = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    chk("rst_mid_an", an, 4'b1110);
    chk("rst_mid_sseg", sseg, 8'hFF);
    reset = 1'b0;
    dc0 = done_cnt;
    v = '{1'b0, 8'd0, 8'hFF, HZ, HZ, 8'hC0};
    check_disp(v, "rst_mid");
    chk("rst_mid_no_done", done_cnt - dc0, 0);

    // Back-to-back loads, each issued the cycle busy falls.
    dprev = 0;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(bb[i]);
      start_load(bb[i]);
      wait_done(0, k, bh);
      chk("b2b_latency", k, LAT);
      e = sb.pop_front();
      if (i > 0) chk("b2b_spacing", cyc - dprev, W_MAG + 2);
      dprev = cyc;
      if (i < 3) begin
        tick();
        chk("b2b_busy_fell", busy, 1'b0);
      end else begin
        check_disp(e, "b2b_last");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
